// File: rtl/riscv_regfile_mp_if.sv
// Bus bundle for the multi-port register file: write ports, read ports,
// scoreboard allocation/flush and the registered write-collision flag.
interface riscv_regfile_mp_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_WR = 4,
    parameter int NUM_RD = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NUM_WR-1:0]      wr_en_i;
    logic [NUM_WR*AW-1:0]   wr_addr_i;
    logic [NUM_WR*XLEN-1:0] wr_data_i;
    logic [NUM_RD*AW-1:0]   rd_addr_i;
    logic [NUM_RD*XLEN-1:0] rd_data_o;
    logic [NUM_RD-1:0]      rd_busy_o;
    logic                   alloc_valid_i;
    logic [AW-1:0]          alloc_addr_i;
    logic                   flush_i;
    logic                   wr_conflict_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, rd_addr_i,
        output alloc_valid_i, alloc_addr_i, flush_i,
        input  rd_data_o, rd_busy_o, wr_conflict_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, rd_addr_i,
        input  alloc_valid_i, alloc_addr_i, flush_i,
        output rd_data_o, rd_busy_o, wr_conflict_o
    );
endinterface

// File: rtl/riscv_regfile_mp.sv
// Multi-write/multi-read register file with a per-register busy scoreboard.
// Define RISCV_REGFILE_BYPASS_EN to forward same-cycle write data to the reads.
module riscv_regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_WR = 4,
    parameter int NUM_RD = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    riscv_regfile_mp_if.slave  rf
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wr_conflict_q;
    logic             wr_conflict_d;

    logic [NREGS-1:0] wr_hit;
    logic [XLEN-1:0]  wr_val [NREGS];

    genvar gi;

    // Per-register write select: later ports overwrite earlier ones, so the
    // highest-index enabled port wins.
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign wr_hit[0] = 1'b0;
                assign wr_val[0] = '0;
                assign regs_d[0] = '0;
                assign busy_d[0] = 1'b0;
            end else begin : g_nz
                logic            hit;
                logic [XLEN-1:0] val;
                logic            alloc_hit;

                always_comb begin
                    hit = 1'b0;
                    val = '0;
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (rf.wr_en_i[k] && rf.wr_addr_i[k*AW +: AW] == AW'(gi)) begin
                            hit = 1'b1;
                            val = rf.wr_data_i[k*XLEN +: XLEN];
                        end
                    end
                end

                assign alloc_hit  = rf.alloc_valid_i && (rf.alloc_addr_i == AW'(gi));
                assign wr_hit[gi] = hit;
                assign wr_val[gi] = val;
                assign regs_d[gi] = hit ? val : regs_q[gi];
                // Flush beats allocation; allocation beats the clearing write
                // because it belongs to a younger instruction.
                assign busy_d[gi] = rf.flush_i ? 1'b0 :
                                    alloc_hit  ? 1'b1 :
                                    hit        ? 1'b0 : busy_q[gi];
            end
        end
    endgenerate

    always_comb begin
        wr_conflict_d = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
            for (int m = k + 1; m < NUM_WR; m++) begin
                if (rf.wr_en_i[k] && rf.wr_en_i[m] &&
                    rf.wr_addr_i[k*AW +: AW] == rf.wr_addr_i[m*AW +: AW] &&
                    rf.wr_addr_i[k*AW +: AW] != '0) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign rf.wr_conflict_o = wr_conflict_q;

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0] addr;
            assign addr = rf.rd_addr_i[gi*AW +: AW];
`ifdef RISCV_REGFILE_BYPASS_EN
            logic alloc_same;
            assign alloc_same = rf.alloc_valid_i && (rf.alloc_addr_i == addr);
            // Forwarding is masked during reset so outputs stay zero.
            assign rf.rd_data_o[gi*XLEN +: XLEN] = rst_i        ? '0 :
                                                   wr_hit[addr] ? wr_val[addr] : regs_q[addr];
            assign rf.rd_busy_o[gi] = rst_i ? 1'b0 :
                                      (wr_hit[addr] && !alloc_same) ? 1'b0 : busy_q[addr];
`else
            assign rf.rd_data_o[gi*XLEN +: XLEN] = regs_q[addr];
            assign rf.rd_busy_o[gi]              = busy_q[addr];
`endif
        end
    endgenerate
endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Directed bench for riscv_regfile_mp (default 32x32, 4 write / 2 read ports).
module tb_riscv_regfile_mp;
    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    riscv_regfile_mp_if #(.XLEN(32), .NREGS(32), .NUM_WR(4), .NUM_RD(2)) bus ();

    riscv_regfile_mp #(.XLEN(32), .NREGS(32), .NUM_WR(4), .NUM_RD(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .rf    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic idle();
        bus.wr_en_i       = '0;
        bus.wr_addr_i     = '0;
        bus.wr_data_i     = '0;
        bus.alloc_valid_i = 1'b0;
        bus.alloc_addr_i  = '0;
        bus.flush_i       = 1'b0;
    endtask

    task automatic set_wr(input int port, input logic [4:0] addr, input logic [31:0] data);
        bus.wr_en_i[port]            = 1'b1;
        bus.wr_addr_i[port*5 +: 5]   = addr;
        bus.wr_data_i[port*32 +: 32] = data;
    endtask

    task automatic alloc(input logic [4:0] addr);
        bus.alloc_valid_i = 1'b1;
        bus.alloc_addr_i  = addr;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        bus.rd_addr_i = {a1, a0};
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] d0();
        return bus.rd_data_o[31:0];
    endfunction

    function automatic logic [31:0] d1();
        return bus.rd_data_o[63:32];
    endfunction

    function automatic logic [31:0] b0();
        return 32'(bus.rd_busy_o[0]);
    endfunction

    function automatic logic [31:0] b1();
        return 32'(bus.rd_busy_o[1]);
    endfunction

    function automatic logic [31:0] cf();
        return 32'(bus.wr_conflict_o);
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        bus.rd_addr_i = '0;
        tick();
        tick();

        $display("[TB] txn: write+alloc x5 while reset held");
        set_wr(0, 5'd5, 32'hAA);
        alloc(5'd5);
        rd(5'd5, 5'd0);
        check_eq("rst_data_x5", d0(), 32'h0);
        tick();
        idle();
        rd(5'd5, 5'd5);
        check_eq("rst_discard_data", d0(), 32'h0);
        check_eq("rst_discard_busy", b0(), 32'h0);
        rst = 1'b0;

        $display("[TB] txn: read all 32 addresses after reset");
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(31 - a));
            check_eq($sformatf("reset_data_x%0d", a), d0(), 32'h0);
            check_eq($sformatf("reset_busy_x%0d", a), b0(), 32'h0);
        end
        check_eq("reset_conflict", cf(), 32'h0);

        $display("[TB] txn: 4-port write x5,x5,x9,x5");
        set_wr(0, 5'd5, 32'h11);
        set_wr(1, 5'd5, 32'h22);
        set_wr(2, 5'd9, 32'h33);
        set_wr(3, 5'd5, 32'h44);
        rd(5'd5, 5'd9);
        check_eq("coll_conflict_same_cycle", cf(), 32'h0);
        tick();
        idle();
        rd(5'd5, 5'd9);
        check_eq("coll_x5", d0(), 32'h44);
        check_eq("coll_x9", d1(), 32'h33);
        check_eq("coll_conflict_next", cf(), 32'h1);
        tick();
        check_eq("coll_conflict_clear", cf(), 32'h0);

        $display("[TB] txn: distinct-address writes x1,x2");
        set_wr(0, 5'd1, 32'h0101);
        set_wr(3, 5'd2, 32'h0202);
        tick();
        idle();
        rd(5'd1, 5'd2);
        check_eq("distinct_x1", d0(), 32'h0101);
        check_eq("distinct_x2", d1(), 32'h0202);
        check_eq("distinct_conflict", cf(), 32'h0);

        $display("[TB] txn: write x0 on two ports + alloc x0");
        set_wr(0, 5'd0, 32'hDEADBEEF);
        set_wr(1, 5'd0, 32'hCAFEF00D);
        alloc(5'd0);
        tick();
        idle();
        rd(5'd0, 5'd0);
        check_eq("x0_data", d0(), 32'h0);
        check_eq("x0_busy", b0(), 32'h0);
        check_eq("x0_conflict", cf(), 32'h0);

        $display("[TB] txn: alloc x7 / write+alloc x7 / write x7");
        alloc(5'd7);
        tick();
        idle();
        rd(5'd7, 5'd0);
        check_eq("alloc_x7_busy", b0(), 32'h1);
        set_wr(2, 5'd7, 32'hA5);
        alloc(5'd7);
        tick();
        idle();
        rd(5'd7, 5'd0);
        check_eq("wr_alloc_x7_busy", b0(), 32'h1);
        check_eq("wr_alloc_x7_data", d0(), 32'hA5);
        set_wr(0, 5'd7, 32'h5A);
        tick();
        idle();
        rd(5'd7, 5'd0);
        check_eq("wr_x7_busy", b0(), 32'h0);
        check_eq("wr_x7_data", d0(), 32'h5A);

        $display("[TB] txn: alloc x3, alloc x4, flush+alloc x6+write x10");
        alloc(5'd3);
        tick();
        alloc(5'd4);
        tick();
        idle();
        rd(5'd3, 5'd4);
        check_eq("alloc_x3_busy", b0(), 32'h1);
        check_eq("alloc_x4_busy", b1(), 32'h1);
        bus.flush_i = 1'b1;
        alloc(5'd6);
        set_wr(1, 5'd10, 32'h77);
        tick();
        idle();
        rd(5'd3, 5'd4);
        check_eq("flush_x3_busy", b0(), 32'h0);
        check_eq("flush_x4_busy", b1(), 32'h0);
        rd(5'd6, 5'd10);
        check_eq("flush_x6_busy", b0(), 32'h0);
        check_eq("flush_x10_data", d1(), 32'h77);

        $display("[TB] txn: write x12 while reading x12");
        set_wr(0, 5'd12, 32'h1111);
        tick();
        idle();
        set_wr(1, 5'd12, 32'h1234);
        rd(5'd12, 5'd12);
`ifdef RISCV_REGFILE_BYPASS_EN
        check_eq("rd_x12_same_cycle", d0(), 32'h1234);
`else
        check_eq("rd_x12_same_cycle", d0(), 32'h1111);
`endif
        tick();
        idle();
        rd(5'd12, 5'd12);
        check_eq("rd_x12_after_edge", d0(), 32'h1234);
        check_eq("rd_x12_port1", d1(), 32'h1234);

        $display("[TB] txn: async reset mid-run with pending write x20");
        alloc(5'd20);
        set_wr(3, 5'd20, 32'h2020);
        rst = 1'b1;
        rd(5'd5, 5'd12);
        check_eq("async_rst_x5", d0(), 32'h0);
        check_eq("async_rst_x12", d1(), 32'h0);
        tick();
        rst = 1'b0;
        idle();
        tick();
        rd(5'd20, 5'd9);
        check_eq("post_rst_x20_data", d0(), 32'h0);
        check_eq("post_rst_x20_busy", b0(), 32'h0);
        check_eq("post_rst_x9", d1(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
